pump_scheduler: RTL

PUMP_SCHEDULER -- requirements
Module: pump_scheduler

---
 rtl/pump_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pump_scheduler.sv
// Four-pump dispense scheduler: latches request edges, grants one pump at a time
// round-robin for a fixed dose, then enforces an idle gap before the next grant.
module pump_scheduler #(
  parameter logic [31:0] DOSE_CYCLES = 32'd50_000_000,
  parameter logic [31:0] GAP_CYCLES  = 32'd5_000_000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [3:0] req,
  input  logic       abort,
  output logic [3:0] pump,
  output logic [1:0] active_id,
  output logic [3:0] pending,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PUMP = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  req_q, req_d;
  logic [3:0]  pump_q, pump_d;
  logic [1:0]  active_id_q, active_id_d;
  logic [3:0]  pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  last_served_q, last_served_d;

  logic [3:0]  rise;
  logic [1:0]  winner;
  logic [1:0]  idx;
  logic        found;

  // Round-robin search starting just after the last served pump; offset 4 wraps back to it.
  always_comb begin
    winner = last_served_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_served_q + 2'(i);
      if (!found && pending_q[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rise          = req & ~req_q;
    req_d         = req;
    state_d       = state_q;
    pump_d        = pump_q;
    active_id_d   = active_id_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    // An edge on the pump currently dispensing is dropped rather than queued.
    pending_d     = pending_q | (rise & ~pump_q);

    case (state_q)
      IDLE: begin
        if (found && !abort) begin
          pump_d      = 4'b0001 << winner;
          active_id_d = winner;
          pending_d   = pending_d & ~(4'b0001 << winner);
          cnt_d       = DOSE_CYCLES - 32'd1;
          state_d     = PUMP;
        end
      end
      PUMP: begin
        if (abort) begin
          pump_d        = '0;
          aborted_d     = 1'b1;
          last_served_d = active_id_q;
          cnt_d         = GAP_CYCLES - 32'd1;
          state_d       = GAP;
        end else if (cnt_q == '0) begin
          pump_d        = '0;
          done_d        = 1'b1;
          last_served_d = active_id_q;
          cnt_d         = GAP_CYCLES - 32'd1;
          state_d       = GAP;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 32'd1;
      end
      default: begin
        state_d = IDLE;
        pump_d  = '0;
      end
    endcase

    if (abort) pending_d = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      req_q         <= '0;
      pump_q        <= '0;
      active_id_q   <= '0;
      pending_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      cnt_q         <= '0;
      last_served_q <= 2'd3;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      pump_q        <= pump_d;
      active_id_q   <= active_id_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
    end
  end

  assign pump      = pump_q;
  assign active_id = active_id_q;
  assign pending   = pending_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule
